mips32_reg_dump: RTL and testbench
==================================

# mips32_reg_dump

Post-halt register-file readout engine for the pipelined MIPS32 core. When the core halts, or on an explicit request, it walks a contiguous (optionally wrapping) range of general-purpose registers through a synchronous register-file read port. It streams each value out as an {index, data} beat on a valid/ready interface. It is the read-back counterpart to register/memory preload, so benches and debug logic can observe architectural state without hierarchical references.

## Interface
- NUM_REGS, 32, number of architectural registers (power of two)
- IDX_W, 5, register index width (log2 NUM_REGS)
- DATA_W, 32, register data width
- clk1  input  1  sole clock, rising-edge
- rst_n  input  1  synchronous active-low reset
- halted  input  1  core HALTED flag; rising edge triggers a dump
- dump_req  input  1  single-cycle request to start a dump (same effect as a halted rising edge)
- dump_first  input  IDX_W  first register index, sampled at trigger
- dump_last  input  IDX_W  last register index, sampled at trigger
- rd_addr  output  IDX_W  register-file read address
- rd_data  input  DATA_W  register-file read data, valid the cycle after rd_addr is driven in READ
- out_valid  output  1  beat valid
- out_ready  input  1  sink accepts beat
- out_idx  output  IDX_W  register index of the beat
- out_data  output  DATA_W  register value of the beat
- out_last  output  1  beat is the final one of the dump
- busy  output  1  dump in progress (state != IDLE)
- done  output  1  one-cycle pulse after the final beat is accepted

## Operation
- Trigger: `trig = dump_req | (halted & ~halted_q)`. `halted_q` is a registered copy of halted and resets to 0, so a core already halted at reset release produces one dump.
- Triggers are honoured only in IDLE. Triggers in any other state are dropped, with no queueing.
- FSM states: IDLE, READ, CAPT, SEND, DONE.
- IDLE: on trig, latch cur_idx <= dump_first and end_idx <= dump_last, then go to READ.
- READ: drive rd_addr = cur_idx, then go to CAPT.
- CAPT: register rd_data into out_data, cur_idx into out_idx, and (cur_idx == end_idx) into out_last. Go to SEND.
- SEND: out_valid = 1.
  - On out_valid & out_ready with out_last = 1: go to DONE.
  - On out_valid & out_ready with out_last = 0: cur_idx <= cur_idx + 1 modulo NUM_REGS (NUM_REGS-1 wraps to 0), then go to READ.
  - Without ready: hold.
- DONE: done = 1 for exactly one cycle, then go to IDLE.
- Range rules:
  - first == last gives exactly one beat.
  - first > last wraps: first..NUM_REGS-1, then 0..last. The beat count is (last - first) mod NUM_REGS + 1.
  - A full 32-register dump is first = last+1 mod 32, e.g. first = 1, last = 0.
- rd_addr holds its last value outside READ. The register file must tolerate reads at any time.

## Timing
- Reset values: state = IDLE, out_valid = 0, out_last = 0, out_idx = 0, out_data = 0, rd_addr = 0, busy = 0, done = 0, halted_q = 0.
- Reset asserted mid-dump: next cycle the block is in IDLE with all outputs at their reset values. No done pulse, no further beats.
- Trigger at cycle T: READ at T+1, CAPT at T+2, first out_valid at T+3.
- With out_ready held high: one beat every 3 cycles. N beats take 3N cycles from READ entry to the final handshake. done is asserted the cycle after the final handshake.
- While out_valid = 1 and out_ready = 0: out_idx, out_data and out_last are stable. out_valid never drops before the handshake.
- out_ready asserted while out_valid = 0 has no effect.
- busy is high from T+1 through the DONE cycle inclusive.
- A new trigger is accepted no earlier than the cycle after DONE, i.e. once the FSM is back in IDLE.

## Test plan
- **Basic halt dump:** register-file model holds R0=0, R1=10, R2=20, R3=25, R4=30, R5=55, Rk=k elsewhere. Set first=0, last=5, raise halted with ready high. Required: 6 beats (0,0), (1,10), (2,20), (3,25), (4,30), (5,55); out_last only on idx 5; done one cycle after; first valid at T+3; beats 3 cycles apart.
- **Backpressure:** first=2, last=3, ready low for 5 cycles after each valid. Required: beat (2,20) held stable during the stall, then (3,25); exactly 2 handshakes; done once.
- **Wrap range:** first=30, last=1 via dump_req. Required: beats with idx 30, 31, 0, 1 (data 30, 31, 0, 10); out_last on idx 1.
- **Single and full dumps:** first=last=7 gives one beat (7,7) with out_last=1. first=1, last=0 gives 32 beats, idx 1..31 then 0.
- **Ignored triggers:** pulse dump_req and toggle halted during an active dump. Required: the current dump is unaffected and no second dump starts. A halted that is already high does not retrigger without a new rising edge.
- **Reset mid-dump:** assert rst_n=0 for one cycle while in SEND at beat 3. Required: next cycle out_valid=0, busy=0, done=0, all outputs at reset values. A fresh dump_req afterwards restarts from dump_first.

Source files
------------

// File: rtl/mips32_reg_dump_if.sv
// Beat stream carrying {index, data} pairs out of the register-file dump engine.
interface mips32_reg_dump_if #(
  parameter int IDX_W  = 5,
  parameter int DATA_W = 32
);
  logic              out_valid;
  logic              out_ready;
  logic [IDX_W-1:0]  out_idx;
  logic [DATA_W-1:0] out_data;
  logic              out_last;

  modport master (
    output out_valid,
    output out_idx,
    output out_data,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_idx,
    input  out_data,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/mips32_reg_dump.sv
// Post-halt register-file readout: walks a (possibly wrapping) index range through a
// synchronous read port and streams each register as one {index, data} beat.
module mips32_reg_dump #(
  parameter int NUM_REGS = 32,
  parameter int IDX_W    = 5,
  parameter int DATA_W   = 32
) (
  input  logic                 clk1,
  input  logic                 rst_n,
  input  logic                 halted,
  input  logic                 dump_req,
  input  logic [IDX_W-1:0]     dump_first,
  input  logic [IDX_W-1:0]     dump_last,
  output logic [IDX_W-1:0]     rd_addr,
  input  logic [DATA_W-1:0]    rd_data,
  mips32_reg_dump_if.master    stream,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    CAPT,
    SEND,
    DONE
  } state_t;

  localparam logic [IDX_W-1:0] TOP_IDX = IDX_W'(NUM_REGS - 1);

  state_t            state;
  logic              halted_q;
  logic [IDX_W-1:0]  cur_idx;
  logic [IDX_W-1:0]  end_idx;
  logic              valid_q;
  logic [IDX_W-1:0]  idx_q;
  logic [DATA_W-1:0] data_q;
  logic              last_q;
  logic              busy_q;
  logic              done_q;
  logic              trig;

  // halted_q starts at 0, so a core that is already halted at reset release still dumps once.
  assign trig = dump_req | (halted & ~halted_q);

  // cur_idx only changes on entry to READ, so it doubles as the held read address.
  assign rd_addr          = cur_idx;
  assign stream.out_valid = valid_q;
  assign stream.out_idx   = idx_q;
  assign stream.out_data  = data_q;
  assign stream.out_last  = last_q;
  assign busy             = busy_q;
  assign done             = done_q;

  // NOTE: every register here is updated with <= so all of them see pre-edge values;
  // a blocking assignment would let a later statement observe the new state mid-cycle.
  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      state    <= IDLE;
      halted_q <= 1'b0;
      cur_idx  <= '0;
      end_idx  <= '0;
      valid_q  <= 1'b0;
      idx_q    <= '0;
      data_q   <= '0;
      last_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      halted_q <= halted;
      case (state)
        IDLE: begin
          if (trig) begin
            cur_idx <= dump_first;
            end_idx <= dump_last;
            busy_q  <= 1'b1;
            state   <= READ;
          end
        end
        READ: begin
          state <= CAPT;
        end
        CAPT: begin
          data_q  <= rd_data;
          idx_q   <= cur_idx;
          last_q  <= (cur_idx == end_idx);
          valid_q <= 1'b1;
          state   <= SEND;
        end
        SEND: begin
          if (stream.out_ready) begin
            valid_q <= 1'b0;
            if (last_q) begin
              done_q <= 1'b1;
              state  <= DONE;
            end else begin
              // Wrap past the top register so first > last ranges continue at 0.
              cur_idx <= (cur_idx == TOP_IDX) ? '0 : cur_idx + 1'b1;
              state   <= READ;
            end
          end
        end
        DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips32_reg_dump.sv
// Directed bench for mips32_reg_dump: table of dump ranges plus hand-written sequences
// for ignored triggers and reset in the middle of a dump.
module tb_mips32_reg_dump;
  localparam int NUM_REGS = 32;
  localparam int IDX_W    = 5;
  localparam int DATA_W   = 32;

  logic              clk1 = 1'b0;
  logic              rst_n = 1'b0;
  logic              halted = 1'b0;
  logic              dump_req = 1'b0;
  logic [IDX_W-1:0]  dump_first = '0;
  logic [IDX_W-1:0]  dump_last = '0;
  logic [IDX_W-1:0]  rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              busy;
  logic              done;

  logic [DATA_W-1:0] regs [NUM_REGS];
  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;

  typedef struct {
    logic [IDX_W-1:0] first;
    logic [IDX_W-1:0] last;
    bit               use_req;
    int               stall;
    int               n_beats;
    string            name;
  } vec_t;

  mips32_reg_dump_if #(.IDX_W(IDX_W), .DATA_W(DATA_W)) stream ();

  mips32_reg_dump #(
    .NUM_REGS(NUM_REGS),
    .IDX_W   (IDX_W),
    .DATA_W  (DATA_W)
  ) dut (
    .clk1      (clk1),
    .rst_n     (rst_n),
    .halted    (halted),
    .dump_req  (dump_req),
    .dump_first(dump_first),
    .dump_last (dump_last),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .stream    (stream.master),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk1 = ~clk1;

  // Synchronous register-file read port model and cycle counter.
  always @(posedge clk1) begin
    cyc     <= cyc + 1;
    rd_data <= regs[rd_addr];
  end

  function automatic logic [DATA_W-1:0] exp_data(input logic [IDX_W-1:0] idx);
    case (idx)
      5'd1:    return 32'd10;
      5'd2:    return 32'd20;
      5'd3:    return 32'd25;
      5'd4:    return 32'd30;
      5'd5:    return 32'd55;
      default: return {27'd0, idx};
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " out_valid"}, 64'(stream.out_valid), 64'd0);
    check({tag, " busy"},      64'(busy),             64'd0);
    check({tag, " done"},      64'(done),             64'd0);
    check({tag, " out_idx"},   64'(stream.out_idx),   64'd0);
    check({tag, " out_data"},  64'(stream.out_data),  64'd0);
    check({tag, " out_last"},  64'(stream.out_last),  64'd0);
    check({tag, " rd_addr"},   64'(rd_addr),          64'd0);
  endtask

  // Starts at a falling edge, fires the trigger, checks every beat and the done pulse.
  task automatic run_dump(input vec_t v);
    int               t_prev;
    int               t_now;
    int               budget;
    bit               stable;
    bit               timed_out;
    logic [IDX_W-1:0] e_idx;
    logic [IDX_W-1:0] h_idx;
    logic [DATA_W-1:0] h_data;
    logic             h_last;

    dump_first       = v.first;
    dump_last        = v.last;
    stream.out_ready = (v.stall == 0);
    if (v.use_req) dump_req = 1'b1;
    else           halted   = 1'b1;
    t_prev = cyc;
    @(negedge clk1);
    dump_req = 1'b0;
    check({v.name, " busy_at_T1"}, 64'(busy), 64'd1);

    e_idx     = v.first;
    timed_out = 1'b0;
    for (int k = 0; k < v.n_beats; k++) begin
      budget = 0;
      while (!stream.out_valid && budget < 12) begin
        @(negedge clk1);
        budget++;
      end
      if (!stream.out_valid) begin
        check({v.name, " valid_timeout"}, 64'd0, 64'd1);
        timed_out = 1'b1;
        break;
      end
      t_now = cyc;
      if (k == 0 || v.stall == 0)
        check({v.name, " beat_spacing"}, 64'(t_now - t_prev), 64'd3);
      check({v.name, " out_idx"},  64'(stream.out_idx),  64'(e_idx));
      check({v.name, " out_data"}, 64'(stream.out_data), 64'(exp_data(e_idx)));
      check({v.name, " out_last"}, 64'(stream.out_last), 64'(k == v.n_beats - 1));
      if (v.stall > 0) begin
        h_idx  = stream.out_idx;
        h_data = stream.out_data;
        h_last = stream.out_last;
        stable = 1'b1;
        repeat (v.stall) begin
          @(negedge clk1);
          if (!stream.out_valid || stream.out_idx !== h_idx ||
              stream.out_data !== h_data || stream.out_last !== h_last)
            stable = 1'b0;
        end
        check({v.name, " stall_stable"}, 64'(stable), 64'd1);
        stream.out_ready = 1'b1;
        @(negedge clk1);
        stream.out_ready = 1'b0;
      end else begin
        @(negedge clk1);
      end
      t_prev = t_now;
      e_idx  = e_idx + 1'b1;
    end

    if (!timed_out) begin
      check({v.name, " done_pulse"},   64'(done),             64'd1);
      check({v.name, " busy_in_done"}, 64'(busy),             64'd1);
      check({v.name, " valid_after"},  64'(stream.out_valid), 64'd0);
      @(negedge clk1);
      check({v.name, " done_one_cycle"}, 64'(done), 64'd0);
      check({v.name, " busy_cleared"},   64'(busy), 64'd0);
    end
    if (!v.use_req) halted = 1'b0;
  endtask

  vec_t vecs [5];
  vec_t vi;
  bit   quiet;
  int   beats_seen;
  int   budget;

  initial begin
    for (int i = 0; i < NUM_REGS; i++) regs[i] = DATA_W'(i);
    regs[1] = 32'd10;
    regs[2] = 32'd20;
    regs[3] = 32'd25;
    regs[4] = 32'd30;
    regs[5] = 32'd55;

    vecs[0] = '{first: 5'd0,  last: 5'd5,  use_req: 1'b0, stall: 0, n_beats: 6,  name: "basic_halt"};
    vecs[1] = '{first: 5'd2,  last: 5'd3,  use_req: 1'b1, stall: 5, n_beats: 2,  name: "backpressure"};
    vecs[2] = '{first: 5'd30, last: 5'd1,  use_req: 1'b1, stall: 0, n_beats: 4,  name: "wrap"};
    vecs[3] = '{first: 5'd7,  last: 5'd7,  use_req: 1'b1, stall: 0, n_beats: 1,  name: "single"};
    vecs[4] = '{first: 5'd1,  last: 5'd0,  use_req: 1'b0, stall: 0, n_beats: 32, name: "full"};

    stream.out_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk1);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk1);

    for (int i = 0; i < 5; i++) begin
      run_dump(vecs[i]);
      repeat (2) @(negedge clk1);
    end

    // Triggers during an active dump must be dropped; a held-high halted must not retrigger.
    vi = '{first: 5'd0, last: 5'd3, use_req: 1'b1, stall: 0, n_beats: 4, name: "ignored"};
    fork
      run_dump(vi);
      begin
        repeat (4) @(negedge clk1);
        dump_req   = 1'b1;
        dump_first = 5'd20;
        dump_last  = 5'd21;
        @(negedge clk1);
        dump_req = 1'b0;
        repeat (2) @(negedge clk1);
        halted = 1'b1;
        repeat (2) @(negedge clk1);
        halted = 1'b0;
        @(negedge clk1);
        halted = 1'b1;
      end
    join
    quiet = 1'b1;
    repeat (8) begin
      @(negedge clk1);
      if (busy || stream.out_valid) quiet = 1'b0;
    end
    check("ignored no_second_dump", 64'(quiet), 64'd1);
    halted = 1'b0;
    repeat (2) @(negedge clk1);

    // Reset while the third beat is being offered.
    dump_first       = 5'd0;
    dump_last        = 5'd5;
    stream.out_ready = 1'b1;
    dump_req         = 1'b1;
    @(negedge clk1);
    dump_req   = 1'b0;
    beats_seen = 0;
    budget     = 0;
    while (budget < 30) begin
      if (stream.out_valid) begin
        beats_seen++;
        if (beats_seen == 3) break;
      end
      @(negedge clk1);
      budget++;
    end
    check("midreset reached_beat3", 64'(beats_seen), 64'd3);
    check("midreset beat3_idx", 64'(stream.out_idx), 64'd2);
    rst_n = 1'b0;
    @(negedge clk1);
    rst_n = 1'b1;
    check_reset_outputs("midreset");
    quiet = 1'b1;
    repeat (6) begin
      @(negedge clk1);
      if (busy || done || stream.out_valid) quiet = 1'b0;
    end
    check("midreset stays_idle", 64'(quiet), 64'd1);
    vi = '{first: 5'd4, last: 5'd5, use_req: 1'b1, stall: 0, n_beats: 2, name: "restart"};
    run_dump(vi);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
